// File: rtl/onehot_decoder_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with handshake, hold time and upward scan.
// Define DEC_ACTIVE_LOW_EN to make dec_out active-low (inactive value all ones).
module onehot_decoder_seq #(
    parameter int SEL_W    = 2,
    parameter int HOLD_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_scan,
    input  logic                  en,
    input  logic                  abort,
    output logic [(1<<SEL_W)-1:0] dec_out,
    output logic                  busy,
    output logic                  done
);
    localparam int OUT_W = 1 << SEL_W;
    localparam int CNT_W = $clog2(HOLD_CYC + 1);
    localparam logic [SEL_W-1:0] CODE_MAX = SEL_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYC - 1);

    typedef enum logic {IDLE, DRIVE} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   code_q, code_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               scan_q, scan_d;
    logic [OUT_W-1:0]   dec_q, dec_d;
    logic               last_q, last_d;
    logic [OUT_W-1:0]   dec_raw;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        scan_d  = scan_q;
        case (state_q)
            IDLE: begin
                if (in_valid && !abort) begin
                    state_d = DRIVE;
                    code_d  = in_sel;
                    scan_d  = in_scan;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (en) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        // Scan stops at the top code rather than wrapping
                        if (!scan_q || code_q == CODE_MAX) state_d = IDLE;
                        else code_d = code_q + SEL_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        dec_d  = (state_d == DRIVE) ? (OUT_W'(1) << code_d) : '0;
        // Flags the final hold cycle of the final code ahead of time
        last_d = (state_d == DRIVE) && (cnt_d == CNT_LAST) && (!scan_d || code_d == CODE_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            cnt_q   <= '0;
            scan_q  <= 1'b0;
            dec_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            scan_q  <= scan_d;
            dec_q   <= dec_d;
            last_q  <= last_d;
        end
    end

    // en=0 blanks the output in the same cycle it pauses the counter
    assign dec_raw  = en ? dec_q : '0;
`ifdef DEC_ACTIVE_LOW_EN
    assign dec_out  = ~dec_raw;
`else
    assign dec_out  = dec_raw;
`endif
    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q == DRIVE);
    assign done     = last_q & en & ~abort;
endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Randomized + directed bench for onehot_decoder_seq against a queue-based plan model.
module tb_onehot_decoder_seq;
    localparam int SEL_W    = 2;
    localparam int HOLD_CYC = 2;
    localparam int OUT_W    = 1 << SEL_W;

    logic             clk = 1'b0;
    logic             rst, in_valid, in_ready, in_scan, en, abort, busy, done;
    logic [SEL_W-1:0] in_sel;
    logic [OUT_W-1:0] dec_out;

    int n_chk = 0;
    int n_err = 0;
    int plan[$];   // one entry per remaining driven cycle: the code to show

    onehot_decoder_seq #(.SEL_W(SEL_W), .HOLD_CYC(HOLD_CYC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_scan(in_scan), .en(en), .abort(abort),
        .dec_out(dec_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic v, input int s, input logic sc,
                       input logic e, input logic a);
        logic             bsy;
        logic [OUT_W-1:0] exp_dec;
        int               top;
        @(negedge clk);
        rst = r; in_valid = v; in_sel = SEL_W'(s); in_scan = sc; en = e; abort = a;
        #1;
        bsy     = (plan.size() != 0);
        exp_dec = (bsy && e) ? (OUT_W'(1) << plan[0]) : '0;
`ifdef DEC_ACTIVE_LOW_EN
        exp_dec = ~exp_dec;
`endif
        chk("dec_out", 64'(dec_out), 64'(exp_dec));
        chk("in_ready", 64'(in_ready), 64'(!bsy));
        chk("busy", 64'(busy), 64'(bsy));
        chk("done", 64'(done), 64'(bsy && e && !a && plan.size() == 1));
        if (r || a) plan.delete();
        else if (bsy && e) void'(plan.pop_front());
        else if (!bsy && v) begin
            top = sc ? OUT_W - 1 : s;
            for (int c = s; c <= top; c++)
                for (int h = 0; h < HOLD_CYC; h++) plan.push_back(c);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_scan = 1'b0; en = 1'b1; abort = 1'b0;
        @(posedge clk);
        repeat (3) cyc(1, 0, 0, 0, 1, 0);
        // single decode of code 2
        cyc(0, 1, 2, 0, 1, 0);
        repeat (4) cyc(0, 0, 0, 0, 1, 0);
        // scan from 1, then scan from the top code
        cyc(0, 1, 1, 1, 1, 0);
        repeat (7) cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 3, 1, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 1, 0);
        // pause during the second cycle of code 0
        cyc(0, 1, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        repeat (8) cyc(0, 0, 0, 0, 1, 0);
        // abort in first cycle of code 2, then reset mid-operation
        cyc(0, 1, 1, 1, 1, 0);
        repeat (2) cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 1, 1);
        repeat (2) cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 0, 1, 0);
        // abort with a request in IDLE must not accept
        cyc(0, 1, 2, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 0);
        // random traffic, requester holds valid while busy
        for (int i = 0; i < 600; i++)
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                int'($urandom_range(0, OUT_W - 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 4) != 0), ($urandom_range(0, 24) == 0));
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
